// File: rtl/jtag_tap_sampler.sv
// Oversampling JTAG TAP slave clocked by the fabric clock.
// Provides IDCODE, BYPASS and GPIO_OUT/GPIO_IN data registers.
module jtag_tap_sampler #(
    parameter logic [31:0] pIDCODE = 32'h0C0D_E001,
    parameter int          pGPIO_W = 8
) (
    input  logic               iCLK,
    input  logic               iRESETn,
    input  logic               iTCK,
    input  logic               iTMS,
    input  logic               iTDI,
    output logic               oTDO,
    output logic               oTDO_EN,
    input  logic [pGPIO_W-1:0] iGPIO_IN,
    output logic [pGPIO_W-1:0] oGPIO_OUT,
    output logic               oGPIO_STB,
    output logic [3:0]         oTAP_STATE
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_e;

    localparam logic [3:0] IR_IDCODE = 4'h1;
    localparam logic [3:0] IR_GOUT   = 4'h2;
    localparam logic [3:0] IR_GIN    = 4'h3;

    logic [2:0]         tck_q;
    logic [1:0]         tms_q;
    logic [1:0]         tdi_q;
    logic [pGPIO_W-1:0] gin1_q;
    logic [pGPIO_W-1:0] gin2_q;
    tap_e               state_q;
    tap_e               state_d;
    logic [3:0]         ir_q;
    logic [3:0]         irsr_q;
    logic [31:0]        dr_q;
    logic [31:0]        dr_cap_d;
    logic [31:0]        dr_sh_d;
    logic [pGPIO_W-1:0] gpio_q;
    logic               stb_q;
    logic               tdo_q;
    logic               rise;
    logic               fall;
    logic               tms;
    logic               tdi;

    assign rise = tck_q[1] & ~tck_q[2];
    assign fall = ~tck_q[1] & tck_q[2];
    assign tms  = tms_q[1];
    assign tdi  = tdi_q[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Unknown codes fall through to the 1-bit bypass register
    always_comb begin
        dr_cap_d = '0;
        dr_sh_d  = {31'b0, tdi};
        unique case (ir_q)
            IR_IDCODE: begin
                dr_cap_d = pIDCODE;
                dr_sh_d  = {tdi, dr_q[31:1]};
            end
            IR_GOUT: begin
                dr_cap_d = 32'(gpio_q);
                dr_sh_d  = 32'({tdi, dr_q[pGPIO_W-1:1]});
            end
            IR_GIN: begin
                dr_cap_d = 32'(gin2_q);
                dr_sh_d  = 32'({tdi, dr_q[pGPIO_W-1:1]});
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            tck_q   <= '0;
            tms_q   <= '0;
            tdi_q   <= '0;
            gin1_q  <= '0;
            gin2_q  <= '0;
            state_q <= TLR;
            ir_q    <= IR_IDCODE;
            irsr_q  <= '0;
            dr_q    <= '0;
            gpio_q  <= '0;
            stb_q   <= 1'b0;
            tdo_q   <= 1'b0;
        end else begin
            tck_q  <= {tck_q[1:0], iTCK};
            tms_q  <= {tms_q[0], iTMS};
            tdi_q  <= {tdi_q[0], iTDI};
            gin1_q <= iGPIO_IN;
            gin2_q <= gin1_q;
            stb_q  <= 1'b0;
            if (rise) begin
                state_q <= state_d;
                unique case (state_q)
                    CAP_IR:  irsr_q <= 4'b0001;
                    SH_IR:   irsr_q <= {tdi, irsr_q[3:1]};
                    CAP_DR:  dr_q   <= dr_cap_d;
                    SH_DR:   dr_q   <= dr_sh_d;
                    default: ;
                endcase
                if (state_d == UPD_IR) ir_q <= irsr_q;
                if (state_d == UPD_DR && ir_q == IR_GOUT) begin
                    gpio_q <= dr_q[pGPIO_W-1:0];
                    stb_q  <= 1'b1;
                end
            end
            if (fall) tdo_q <= (state_q == SH_IR) ? irsr_q[0] : dr_q[0];
            if (state_q == TLR) ir_q <= IR_IDCODE;
        end
    end

    assign oTDO_EN    = (state_q == SH_IR) || (state_q == SH_DR);
    assign oTDO       = tdo_q & oTDO_EN;
    assign oGPIO_OUT  = gpio_q;
    assign oGPIO_STB  = stb_q;
    assign oTAP_STATE = state_q;

endmodule

// File: tb/tb_jtag_tap_sampler.sv
// Directed bench for jtag_tap_sampler: bit-bangs JTAG scans
// on the pins and checks TDO, state, GPIO word and strobe.
module tb_jtag_tap_sampler;

    localparam logic [31:0] ID = 32'h0C0D_E001;
    localparam int          W  = 8;

    logic         iCLK     = 1'b0;
    logic         iRESETn  = 1'b0;
    logic         iTCK     = 1'b0;
    logic         iTMS     = 1'b0;
    logic         iTDI     = 1'b0;
    logic [W-1:0] iGPIO_IN = '0;
    logic         oTDO;
    logic         oTDO_EN;
    logic [W-1:0] oGPIO_OUT;
    logic         oGPIO_STB;
    logic [3:0]   oTAP_STATE;

    int   total   = 0;
    int   bad     = 0;
    int   stb_cnt = 0;
    logic last_tdo;
    logic last_en;

    jtag_tap_sampler #(.pIDCODE(ID), .pGPIO_W(W)) dut (
        .iCLK      (iCLK),
        .iRESETn   (iRESETn),
        .iTCK      (iTCK),
        .iTMS      (iTMS),
        .iTDI      (iTDI),
        .oTDO      (oTDO),
        .oTDO_EN   (oTDO_EN),
        .iGPIO_IN  (iGPIO_IN),
        .oGPIO_OUT (oGPIO_OUT),
        .oGPIO_STB (oGPIO_STB),
        .oTAP_STATE(oTAP_STATE)
    );

    always #4 iCLK = ~iCLK;

    always @(posedge iCLK) if (oGPIO_STB === 1'b1) stb_cnt <= stb_cnt + 1;

    // One TCK period; TDO/EN are sampled just before the rising pin edge
    task automatic tck(input logic tms, input logic tdi, input int hi);
        iTMS = tms;
        iTDI = tdi;
        repeat (2) @(negedge iCLK);
        last_tdo = oTDO;
        last_en  = oTDO_EN;
        iTCK = 1'b1;
        repeat (hi) @(negedge iCLK);
        iTCK = 1'b0;
        repeat (6) @(negedge iCLK);
    endtask

    task automatic do_reset();
        iRESETn = 1'b0;
        repeat (2) @(negedge iCLK);
        iRESETn = 1'b1;
        @(negedge iCLK);
    endtask

    task automatic ir_scan(input logic [3:0] v, output logic [3:0] o);
        o = '0;
        tck(1'b1, 1'b0, 6);
        tck(1'b1, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            tck(i == 3, v[i], 6);
            o[i] = last_tdo;
        end
        tck(1'b1, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] v,
                           output logic [31:0] o, output int en_bad);
        o      = '0;
        en_bad = 0;
        tck(1'b1, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        if (last_en !== 1'b0) en_bad++;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, v[i], 6);
            o[i] = last_tdo;
            if (last_en !== 1'b1) en_bad++;
        end
        tck(1'b1, 1'b0, 6);
        if (last_en !== 1'b0) en_bad++;
        tck(1'b0, 1'b0, 6);
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(negedge iCLK);
        total++;
        if (oTAP_STATE !== 4'hF) begin
            bad++;
            $display("FAIL reset_state got=%h want=F", oTAP_STATE);
        end
        total++;
        if (oTDO_EN !== 1'b0 || oTDO !== 1'b0) begin
            bad++;
            $display("FAIL reset_tdo got en=%b tdo=%b want 0 0", oTDO_EN, oTDO);
        end
        total++;
        if (oGPIO_OUT !== 8'h00) begin
            bad++;
            $display("FAIL reset_gpio got=%h want=00", oGPIO_OUT);
        end
        total++;
        if (stb_cnt !== 0) begin
            bad++;
            $display("FAIL reset_stb got=%0d want=0", stb_cnt);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] o;
        int          eb;
        tck(1'b0, 1'b0, 6);
        total++;
        if (oTAP_STATE !== 4'hC) begin
            bad++;
            $display("FAIL idcode_rti got=%h want=C", oTAP_STATE);
        end
        dr_scan(32, 32'h0, o, eb);
        total++;
        if (o !== ID) begin
            bad++;
            $display("FAIL idcode_data got=%h want=%h", o, ID);
        end
        total++;
        if (eb !== 0) begin
            bad++;
            $display("FAIL idcode_en got=%0d bad samples want=0", eb);
        end
    endtask

    task automatic test_gpio_out();
        logic [3:0]  ir;
        logic [31:0] o;
        int          eb;
        int          s0;
        ir_scan(4'h2, ir);
        total++;
        if (ir !== 4'b0001) begin
            bad++;
            $display("FAIL gout_ir_tdo got=%b want=0001", ir);
        end
        s0 = stb_cnt;
        dr_scan(8, 32'hA5, o, eb);
        total++;
        if (o[7:0] !== 8'h00) begin
            bad++;
            $display("FAIL gout_cap0 got=%h want=00", o[7:0]);
        end
        total++;
        if (oGPIO_OUT !== 8'hA5) begin
            bad++;
            $display("FAIL gout_word got=%h want=A5", oGPIO_OUT);
        end
        repeat (3) tck(1'b0, 1'b0, 6);
        total++;
        if (stb_cnt - s0 !== 1) begin
            bad++;
            $display("FAIL gout_stb got=%0d want=1", stb_cnt - s0);
        end
        total++;
        if (oTAP_STATE !== 4'hC) begin
            bad++;
            $display("FAIL gout_rti got=%h want=C", oTAP_STATE);
        end
        dr_scan(8, 32'h5A, o, eb);
        total++;
        if (o[7:0] !== 8'hA5) begin
            bad++;
            $display("FAIL gout_cap1 got=%h want=A5", o[7:0]);
        end
        total++;
        if (oGPIO_OUT !== 8'h5A || stb_cnt - s0 !== 2) begin
            bad++;
            $display("FAIL gout_b2b got=%h/%0d want=5A/2",
                     oGPIO_OUT, stb_cnt - s0);
        end
    endtask

    task automatic test_gpio_in();
        logic [3:0]  ir;
        logic [31:0] o;
        int          eb;
        int          s0;
        iGPIO_IN = 8'h3C;
        s0 = stb_cnt;
        ir_scan(4'h3, ir);
        dr_scan(8, 32'h0, o, eb);
        total++;
        if (o[7:0] !== 8'h3C) begin
            bad++;
            $display("FAIL gin_data got=%h want=3C", o[7:0]);
        end
        total++;
        if (oGPIO_OUT !== 8'h5A || stb_cnt !== s0) begin
            bad++;
            $display("FAIL gin_nostb got=%h/%0d want=5A/0",
                     oGPIO_OUT, stb_cnt - s0);
        end
    endtask

    task automatic test_bypass();
        logic [3:0]  ir;
        logic [31:0] o;
        int          eb;
        ir_scan(4'h7, ir);
        dr_scan(4, 32'b1101, o, eb);
        total++;
        if (o[3:0] !== 4'b1010) begin
            bad++;
            $display("FAIL bypass_7 got=%b want=1010", o[3:0]);
        end
        ir_scan(4'hF, ir);
        dr_scan(4, 32'b0011, o, eb);
        total++;
        if (o[3:0] !== 4'b0110) begin
            bad++;
            $display("FAIL bypass_f got=%b want=0110", o[3:0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0]  ir;
        logic [31:0] o;
        int          eb;
        int          s0;
        ir_scan(4'h2, ir);
        s0 = stb_cnt;
        tck(1'b1, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        repeat (4) tck(1'b0, 1'b1, 6);
        total++;
        if (oTAP_STATE !== 4'h2) begin
            bad++;
            $display("FAIL mid_shdr got=%h want=2", oTAP_STATE);
        end
        do_reset();
        repeat (4) @(negedge iCLK);
        total++;
        if (oTAP_STATE !== 4'hF || oGPIO_OUT !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got=%h/%h want=F/00",
                     oTAP_STATE, oGPIO_OUT);
        end
        total++;
        if (stb_cnt !== s0) begin
            bad++;
            $display("FAIL mid_stb got=%0d want=0", stb_cnt - s0);
        end
        tck(1'b0, 1'b0, 6);
        dr_scan(32, 32'h0, o, eb);
        total++;
        if (o !== ID) begin
            bad++;
            $display("FAIL mid_ir got=%h want=%h", o, ID);
        end
    endtask

    task automatic test_tlr_from_pause();
        logic [3:0]  ir;
        logic [31:0] o;
        int          eb;
        ir_scan(4'h3, ir);
        tck(1'b1, 1'b0, 6);
        tck(1'b1, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        tck(1'b0, 1'b1, 6);
        tck(1'b1, 1'b0, 6);
        tck(1'b0, 1'b0, 6);
        total++;
        if (oTAP_STATE !== 4'hB) begin
            bad++;
            $display("FAIL pause_ir got=%h want=B", oTAP_STATE);
        end
        repeat (5) tck(1'b1, 1'b0, 6);
        total++;
        if (oTAP_STATE !== 4'hF) begin
            bad++;
            $display("FAIL pause_tlr got=%h want=F", oTAP_STATE);
        end
        tck(1'b0, 1'b0, 6);
        dr_scan(32, 32'h0, o, eb);
        total++;
        if (o !== ID) begin
            bad++;
            $display("FAIL pause_idcode got=%h want=%h", o, ID);
        end
    endtask

    task automatic test_fast_high();
        logic [3:0] exp [6];
        logic [0:0] tms [6];
        exp = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h5};
        tms = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (5) tck(1'b1, 1'b0, 4);
        total++;
        if (oTAP_STATE !== 4'hF) begin
            bad++;
            $display("FAIL fast_tlr got=%h want=F", oTAP_STATE);
        end
        for (int i = 0; i < 6; i++) begin
            tck(tms[i][0], 1'b0, 4);
            total++;
            if (oTAP_STATE !== exp[i]) begin
                bad++;
                $display("FAIL fast_step%0d got=%h want=%h",
                         i, oTAP_STATE, exp[i]);
            end
        end
    endtask

    initial begin
        @(negedge iCLK);
        test_reset();
        test_idcode();
        test_gpio_out();
        test_gpio_in();
        test_bypass();
        test_reset_mid_scan();
        test_tlr_from_pause();
        test_fast_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
